alu_bist_sequencer: RTL



---
 rtl/alu_bist_sequencer_if.sv | 23 ++
 rtl/alu_bist_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_bist_sequencer_if.sv
// ALU stimulus/response bus: the self-test sequencer drives operands and selector (master),
// and the combinational ALU returns result and flags (slave).
interface alu_bist_sequencer_if #(
    parameter int N = 4
);
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_sel_n;
    logic         alu_cin;
    logic [N-1:0] alu_result;
    logic         alu_zero;
    logic         alu_cout;

    modport master (
        output alu_a, alu_b, alu_sel_n, alu_cin,
        input  alu_result, alu_zero, alu_cout
    );

    modport slave (
        input  alu_a, alu_b, alu_sel_n, alu_cin,
        output alu_result, alu_zero, alu_cout
    );
endinterface

// File: rtl/alu_bist_sequencer.sv
// ALU self-test: sweeps opcodes 0..9 x PAIRS LFSR vectors, 2 cycles/vector (DRIVE, SAMPLE), no backpressure.
// Define ALU_BIST_FLAG_CHECK_EN to also check alu_zero (all ops) and alu_cout (add).
module alu_bist_sequencer #(
    parameter int          N     = 4,
    parameter int          PAIRS = 16,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_bist_sequencer_if.master alu,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [7:0]           err_count,
    output logic [3:0]           fail_op,
    output logic [N-1:0]         fail_a,
    output logic [N-1:0]         fail_b
);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_e;

    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LAST_PAIR = 16'(PAIRS - 1);

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    state_e       state_q, state_d;
    logic [3:0]   op_q, op_d, nxt_op;
    logic [15:0]  pair_q, pair_d, nxt_pair;
    logic [15:0]  lfsr_q, lfsr_d;
    logic [N-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]   sel_n_q, sel_n_d;
    logic         cin_q, cin_d;
    logic [7:0]   err_q, err_d;
    logic [3:0]   fail_op_q, fail_op_d;
    logic [N-1:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d;

    logic [N:0]   sum;
    logic [N-1:0] g_res;
    logic         g_cout;
    logic         shift_big;
    logic         mism;

    // Golden ALU evaluated on the registered vector that is held on the ALU ports.
    always_comb begin
        sum       = {1'b0, a_q} + {1'b0, b_q} + {{N{1'b0}}, cin_q};
        g_cout    = sum[N];
        shift_big = (int'({1'b0, b_q}) >= N);
        g_res     = '0;
        case (op_q)
            4'd0:       g_res = sum[N-1:0];
            4'd1:       g_res = b_q - a_q;
            4'd2:       g_res = ~a_q;
            4'd3:       g_res = a_q & b_q;
            4'd4:       g_res = a_q | b_q;
            4'd5:       g_res = a_q ^ b_q;
            4'd6:       g_res = shift_big ? '0 : (a_q >> b_q);
            4'd7, 4'd9: g_res = shift_big ? '0 : (a_q << b_q);
            4'd8:       g_res = shift_big ? {N{a_q[N-1]}} : $unsigned($signed(a_q) >>> b_q);
            default:    g_res = '0;
        endcase
    end

`ifdef ALU_BIST_FLAG_CHECK_EN
    always_comb begin
        mism = (alu.alu_result != g_res);
        if (alu.alu_zero != (g_res == '0)) mism = 1'b1;
        if ((op_q == 4'd0) && (alu.alu_cout != g_cout)) mism = 1'b1;
    end
`else
    logic unused_flags;
    assign unused_flags = alu.alu_zero ^ alu.alu_cout ^ g_cout;
    assign mism         = (alu.alu_result != g_res);
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        pair_d    = pair_q;
        lfsr_d    = lfsr_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_n_d   = sel_n_q;
        cin_d     = cin_q;
        err_d     = err_q;
        fail_op_d = fail_op_q;
        fail_a_d  = fail_a_q;
        fail_b_d  = fail_b_q;
        nxt_op    = op_q;
        nxt_pair  = pair_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_DRIVE;
                    op_d      = 4'd0;
                    pair_d    = 16'd0;
                    lfsr_d    = lfsr_step(SEED_EFF);
                    a_d       = SEED_EFF[N-1:0];
                    b_d       = SEED_EFF[2*N-1:N];
                    sel_n_d   = 4'hF;
                    cin_d     = 1'b0;
                    err_d     = 8'd0;
                    fail_op_d = 4'd0;
                    fail_a_d  = '0;
                    fail_b_d  = '0;
                end
            end
            S_DRIVE: state_d = S_SAMPLE;
            S_SAMPLE: begin
                // err_q is still zero exactly until the first mismatch of the run.
                if (mism) begin
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    if (err_q == 8'd0) begin
                        fail_op_d = op_q;
                        fail_a_d  = a_q;
                        fail_b_d  = b_q;
                    end
                end
                if (pair_q == LAST_PAIR) begin
                    nxt_op   = op_q + 4'd1;
                    nxt_pair = 16'd0;
                end else begin
                    nxt_pair = pair_q + 16'd1;
                end
                if ((op_q == 4'd9) && (pair_q == LAST_PAIR)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRIVE;
                    op_d    = nxt_op;
                    pair_d  = nxt_pair;
                    lfsr_d  = lfsr_step(lfsr_q);
                    a_d     = lfsr_q[N-1:0];
                    b_d     = lfsr_q[2*N-1:N];
                    sel_n_d = ~nxt_op;
                    cin_d   = (nxt_op == 4'd0) && nxt_pair[0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= 4'd0;
            pair_q    <= 16'd0;
            lfsr_q    <= SEED_EFF;
            a_q       <= '0;
            b_q       <= '0;
            sel_n_q   <= 4'hF;
            cin_q     <= 1'b0;
            err_q     <= 8'd0;
            fail_op_q <= 4'd0;
            fail_a_q  <= '0;
            fail_b_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            pair_q    <= pair_d;
            lfsr_q    <= lfsr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sel_n_q   <= sel_n_d;
            cin_q     <= cin_d;
            err_q     <= err_d;
            fail_op_q <= fail_op_d;
            fail_a_q  <= fail_a_d;
            fail_b_q  <= fail_b_d;
        end
    end

    assign busy          = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign done          = (state_q == S_DONE);
    assign pass          = done && (err_q == 8'd0);
    assign err_count     = err_q;
    assign fail_op       = fail_op_q;
    assign fail_a        = fail_a_q;
    assign fail_b        = fail_b_q;
    assign alu.alu_a     = a_q;
    assign alu.alu_b     = b_q;
    assign alu.alu_sel_n = sel_n_q;
    assign alu.alu_cin   = cin_q;

endmodule
